// File: rtl/superscalar_pkg.sv
// -----------------------------------------------------------------------------
// superscalar_pkg
// Shared definitions for the two-lane superscalar decode/issue logic.
//   - state_e    : issue-pair scheduler states (ST_PAIR, ST_SPLIT)
//   - conflict_e : intra-pair conflict codes (CF_NONE, CF_RAW, CF_WAW, CF_MEM)
//   - REG_W      : architectural register index width
// -----------------------------------------------------------------------------
package superscalar_pkg;

    localparam int REG_W = 5;

    typedef enum logic {
        ST_PAIR  = 1'b0,
        ST_SPLIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CF_NONE = 2'd0,
        CF_RAW  = 2'd1,
        CF_WAW  = 2'd2,
        CF_MEM  = 2'd3
    } conflict_e;

endpackage

// File: rtl/pair_conflict_check.sv
// -----------------------------------------------------------------------------
// pair_conflict_check
// Purely combinational intra-pair conflict classifier. It is shared with the
// issue-width monitor, so it only looks at slot fields and carries no state.
//
// Ports
//   valid1_i, valid2_i       : decode slots hold real instructions
//   rs2_i, rt2_i             : slot 2 source registers
//   write_reg1_i/2_i         : slot destination registers
//   reg_write1_i/2_i         : slot writes its destination
//   mem_acc1_i/2_i           : slot uses the single data-memory port
//   conflict_o               : CF_NONE / CF_RAW / CF_WAW / CF_MEM
// -----------------------------------------------------------------------------
module pair_conflict_check
    import superscalar_pkg::*;
(
    input  logic             valid1_i,
    input  logic             valid2_i,
    input  logic [REG_W-1:0] rs2_i,
    input  logic [REG_W-1:0] rt2_i,
    input  logic [REG_W-1:0] write_reg1_i,
    input  logic [REG_W-1:0] write_reg2_i,
    input  logic             reg_write1_i,
    input  logic             reg_write2_i,
    input  logic             mem_acc1_i,
    input  logic             mem_acc2_i,
    output conflict_e        conflict_o
);

    logic raw_hit;
    logic waw_hit;
    logic mem_hit;

    // Writes to $0 are discarded by the register file, so they can never
    // create a dependency between the two slots.
    assign raw_hit = reg_write1_i && (write_reg1_i != '0) &&
                     ((write_reg1_i == rs2_i) || (write_reg1_i == rt2_i));
    assign waw_hit = reg_write1_i && reg_write2_i &&
                     (write_reg1_i == write_reg2_i) && (write_reg1_i != '0);
    assign mem_hit = mem_acc1_i && mem_acc2_i;

    always_comb begin
        conflict_o = CF_NONE;
        if (valid1_i && valid2_i) begin
            if (raw_hit) begin
                conflict_o = CF_RAW;
            end else if (waw_hit) begin
                conflict_o = CF_WAW;
            end else if (mem_hit) begin
                conflict_o = CF_MEM;
            end
        end
    end

endmodule

// File: rtl/issue_pair_scheduler.sv
// -----------------------------------------------------------------------------
// issue_pair_scheduler
// Decides each cycle whether the decoded instruction pair issues together or
// is split: on a split, slot 1 goes first while IF/ID is frozen, and the held
// slot 2 issues on lane 1 in the following cycle.
//
// Ports
//   clk, rst                 : clock, asynchronous active-low reset
//   validD1/2                : decode slot valid
//   rsD1/rtD1/rsD2/rtD2      : source registers
//   writeRegD1/2, regWriteD1/2 : destinations and write enables
//   memAccD1/2               : load/store slots
//   stallD, flushD           : hazard unit decode stall / flush
//   issue1, issue2           : lane 1 / lane 2 ID/EX valid
//   laneSel                  : 1 when lane 1 carries the held slot 2
//   holdIFID                 : freeze PC and IF/ID
//   conflict                 : conflict code of the current pair (PAIR only)
//   splitCount               : saturating number of splits
// -----------------------------------------------------------------------------
module issue_pair_scheduler
    import superscalar_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validD1,
    input  logic             validD2,
    input  logic [REG_W-1:0] rsD1,
    input  logic [REG_W-1:0] rtD1,
    input  logic [REG_W-1:0] rsD2,
    input  logic [REG_W-1:0] rtD2,
    input  logic [REG_W-1:0] writeRegD1,
    input  logic [REG_W-1:0] writeRegD2,
    input  logic             regWriteD1,
    input  logic             regWriteD2,
    input  logic             memAccD1,
    input  logic             memAccD2,
    input  logic             stallD,
    input  logic             flushD,
    output logic             issue1,
    output logic             issue2,
    output logic             laneSel,
    output logic             holdIFID,
    output logic [1:0]       conflict,
    output logic [CNT_W-1:0] splitCount
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] split_count_q, split_count_d;
    conflict_e        pair_conflict;

    logic             issue1_c, issue2_c, lane_sel_c, hold_c;
    logic [1:0]       conflict_c;

    // Slot 1 sources never matter for an intra-pair conflict: slot 1 is older.
    logic unused_slot1_srcs;
    assign unused_slot1_srcs = ^{rsD1, rtD1};

    pair_conflict_check u_conflict (
        .valid1_i     (validD1),
        .valid2_i     (validD2),
        .rs2_i        (rsD2),
        .rt2_i        (rtD2),
        .write_reg1_i (writeRegD1),
        .write_reg2_i (writeRegD2),
        .reg_write1_i (regWriteD1),
        .reg_write2_i (regWriteD2),
        .mem_acc1_i   (memAccD1),
        .mem_acc2_i   (memAccD2),
        .conflict_o   (pair_conflict)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_PAIR;
            split_count_q <= '0;
        end else begin
            state_q       <= state_d;
            split_count_q <= split_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        split_count_d = split_count_q;
        issue1_c      = 1'b0;
        issue2_c      = 1'b0;
        lane_sel_c    = 1'b0;
        hold_c        = 1'b0;
        conflict_c    = CF_NONE;

        case (state_q)
            ST_PAIR: begin
                conflict_c = pair_conflict;
                if (pair_conflict != CF_NONE) begin
                    issue1_c = 1'b1;
                    hold_c   = 1'b1;
                    state_d  = ST_SPLIT;
                    if (split_count_q != '1) begin
                        split_count_d = split_count_q + CNT_W'(1);
                    end
                end else begin
                    issue1_c = validD1;
                    issue2_c = validD2;
                end
            end
            ST_SPLIT: begin
                // Held slot 2 always travels down lane 1 alone.
                issue1_c   = validD2;
                lane_sel_c = 1'b1;
                state_d    = ST_PAIR;
            end
            default: begin
                state_d = ST_PAIR;
            end
        endcase

        // A stall freezes everything, including a pending split, so the
        // counter only moves on a real PAIR->SPLIT transition.
        if (stallD) begin
            issue1_c      = 1'b0;
            issue2_c      = 1'b0;
            hold_c        = 1'b1;
            state_d       = state_q;
            split_count_d = split_count_q;
        end

        // Flush wins over stall and drops any held slot 2.
        if (flushD) begin
            issue1_c      = 1'b0;
            issue2_c      = 1'b0;
            hold_c        = 1'b0;
            state_d       = ST_PAIR;
            split_count_d = split_count_q;
        end
    end

    // Outputs are combinational from state and inputs, so they are forced low
    // directly while reset is held rather than waiting for a clock edge.
    assign issue1     = rst & issue1_c;
    assign issue2     = rst & issue2_c;
    assign laneSel    = rst & lane_sel_c;
    assign holdIFID   = rst & hold_c;
    assign conflict   = rst ? conflict_c : 2'b00;
    assign splitCount = split_count_q;

endmodule

// File: tb/tb_issue_pair_scheduler.sv
module tb_issue_pair_scheduler;

    localparam int TB_CNT_W = 5;
    localparam int MAXC     = (1 << TB_CNT_W) - 1;

    typedef struct {
        logic       v1, v2;
        logic [4:0] rs1, rt1, rs2, rt2, wr1, wr2;
        logic       rw1, rw2, m1, m2;
        logic       stall, flush;
    } slot_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic validD1 = 0, validD2 = 0;
    logic [4:0] rsD1 = 0, rtD1 = 0, rsD2 = 0, rtD2 = 0, writeRegD1 = 0, writeRegD2 = 0;
    logic regWriteD1 = 0, regWriteD2 = 0, memAccD1 = 0, memAccD2 = 0;
    logic stallD = 0, flushD = 0;
    logic issue1, issue2, laneSel, holdIFID;
    logic [1:0] conflict;
    logic [TB_CNT_W-1:0] splitCount;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state: is a slot 2 waiting, and how many splits so far.
    bit m_held  = 0;
    int m_count = 0;

    issue_pair_scheduler #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .validD1(validD1), .validD2(validD2),
        .rsD1(rsD1), .rtD1(rtD1), .rsD2(rsD2), .rtD2(rtD2),
        .writeRegD1(writeRegD1), .writeRegD2(writeRegD2),
        .regWriteD1(regWriteD1), .regWriteD2(regWriteD2),
        .memAccD1(memAccD1), .memAccD2(memAccD2),
        .stallD(stallD), .flushD(flushD),
        .issue1(issue1), .issue2(issue2), .laneSel(laneSel),
        .holdIFID(holdIFID), .conflict(conflict), .splitCount(splitCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic slot_t mk(input logic v1, v2,
                                 input logic [4:0] rs1, rt1, wr1, input logic rw1, m1,
                                 input logic [4:0] rs2, rt2, wr2, input logic rw2, m2);
        slot_t s;
        s.v1 = v1; s.v2 = v2;
        s.rs1 = rs1; s.rt1 = rt1; s.wr1 = wr1; s.rw1 = rw1; s.m1 = m1;
        s.rs2 = rs2; s.rt2 = rt2; s.wr2 = wr2; s.rw2 = rw2; s.m2 = m2;
        s.stall = 0; s.flush = 0;
        return s;
    endfunction

    // Conflict classification straight from the pairing rules.
    function automatic int spec_conflict(input slot_t s);
        if (!(s.v1 && s.v2)) return 0;
        if (s.rw1 && s.wr1 != 0 && (s.wr1 == s.rs2 || s.wr1 == s.rt2)) return 1;
        if (s.rw1 && s.rw2 && s.wr1 == s.wr2 && s.wr1 != 0) return 2;
        if (s.m1 && s.m2) return 3;
        return 0;
    endfunction

    task automatic apply(input slot_t s);
        validD1 = s.v1; validD2 = s.v2;
        rsD1 = s.rs1; rtD1 = s.rt1; rsD2 = s.rs2; rtD2 = s.rt2;
        writeRegD1 = s.wr1; writeRegD2 = s.wr2;
        regWriteD1 = s.rw1; regWriteD2 = s.rw2;
        memAccD1 = s.m1; memAccD2 = s.m2;
        stallD = s.stall; flushD = s.flush;
    endtask

    // One decode cycle: drive at negedge, compare mid-cycle, advance model at posedge.
    task automatic drive(input string name, input slot_t s);
        int cf;
        logic e1, e2, eh, el;
        int ecf;
        @(negedge clk);
        apply(s);
        #1;
        cf  = spec_conflict(s);
        ecf = m_held ? 0 : cf;
        if (m_held) begin
            e1 = s.v2; e2 = 0; eh = 0; el = 1;
        end else if (cf != 0) begin
            e1 = 1; e2 = 0; eh = 1; el = 0;
        end else begin
            e1 = s.v1; e2 = s.v2; eh = 0; el = 0;
        end
        if (s.flush) begin
            e1 = 0; e2 = 0; eh = 0;
        end else if (s.stall) begin
            e1 = 0; e2 = 0; eh = 1;
        end
        check({name, ".issue1"}, 32'(issue1), 32'(e1));
        check({name, ".issue2"}, 32'(issue2), 32'(e2));
        check({name, ".hold"}, 32'(holdIFID), 32'(eh));
        check({name, ".conflict"}, 32'(conflict), 32'(ecf));
        check({name, ".count"}, 32'(splitCount), 32'(m_count));
        if (!s.stall && !s.flush) check({name, ".laneSel"}, 32'(laneSel), 32'(el));
        $display("cyc %0d %s v=%0d%0d st=%0d fl=%0d -> i1=%0d i2=%0d ls=%0d h=%0d cf=%0d cnt=%0d",
                 cyc, name, s.v1, s.v2, s.stall, s.flush, issue1, issue2, laneSel,
                 holdIFID, conflict, splitCount);
        if (s.flush) m_held = 0;
        else if (!s.stall) begin
            if (m_held) m_held = 0;
            else if (cf != 0) begin
                m_held = 1;
                if (m_count < MAXC) m_count++;
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".issue1"}, 32'(issue1), 0);
        check({name, ".issue2"}, 32'(issue2), 0);
        check({name, ".laneSel"}, 32'(laneSel), 0);
        check({name, ".hold"}, 32'(holdIFID), 0);
        check({name, ".conflict"}, 32'(conflict), 0);
        check({name, ".count"}, 32'(splitCount), 0);
    endtask

    initial begin
        slot_t s, idle, indep, raw, zero, loads;
        idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        indep = mk(1, 1, 1, 2, 3, 1, 0, 6, 7, 5, 1, 0);  // add $3,$1,$2 ; sub $5,$6,$7
        raw   = mk(1, 1, 1, 2, 8, 1, 0, 9, 8, 4, 1, 0);  // slot2 reads rt=$8
        zero  = mk(1, 1, 1, 2, 0, 1, 0, 0, 0, 4, 1, 0);  // slot1 writes $0, slot2 reads $0
        loads = mk(1, 1, 1, 0, 2, 1, 1, 3, 0, 4, 1, 1);  // two loads

        // Reset held with a conflicting pair on the inputs: outputs must stay low.
        apply(raw);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        $display("cyc %0d reset i1=%0d h=%0d cf=%0d cnt=%0d", cyc, issue1, holdIFID, conflict, splitCount);
        @(negedge clk);
        apply(idle);
        rst = 1;

        drive("indep", indep);
        drive("raw0", raw);
        drive("raw1", raw);
        drive("zero", zero);
        drive("mem0", loads);
        drive("mem1", loads);
        drive("v2only", mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0));

        // Stall for two cycles while a split is pending.
        drive("sraw", raw);
        s = raw; s.stall = 1;
        drive("stall0", s);
        drive("stall1", s);
        drive("sheld", raw);

        // Flush discards the held slot 2.
        drive("fraw", raw);
        s = raw; s.flush = 1;
        drive("flush", s);
        drive("fnext", indep);

        // Stall and flush together in PAIR with a conflict.
        s = loads; s.stall = 1; s.flush = 1;
        drive("stfl", s);

        // Asynchronous reset mid-split.
        drive("rraw", raw);
        @(negedge clk);
        #2;
        rst = 0;
        #1;
        check_reset_outputs("midrst");
        $display("cyc %0d midrst i1=%0d ls=%0d cnt=%0d", cyc, issue1, laneSel, splitCount);
        @(negedge clk);
        apply(idle);
        rst = 1;
        m_held  = 0;
        m_count = 0;

        // Saturation of the split counter.
        for (int i = 0; i < MAXC + 4; i++) begin
            drive("sat0", raw);
            drive("sat1", raw);
        end
        check("saturate", 32'(splitCount), 32'(MAXC));

        // Randomised traffic with small register indices to provoke conflicts.
        for (int i = 0; i < 600; i++) begin
            s.v1 = ($urandom_range(0, 3) != 0);
            s.v2 = ($urandom_range(0, 3) != 0);
            s.rs1 = 5'($urandom_range(0, 3)); s.rt1 = 5'($urandom_range(0, 3));
            s.rs2 = 5'($urandom_range(0, 3)); s.rt2 = 5'($urandom_range(0, 3));
            s.wr1 = 5'($urandom_range(0, 3)); s.wr2 = 5'($urandom_range(0, 3));
            s.rw1 = 1'($urandom); s.rw2 = 1'($urandom);
            s.m1  = ($urandom_range(0, 2) == 0); s.m2 = ($urandom_range(0, 2) == 0);
            s.stall = ($urandom_range(0, 7) == 0);
            s.flush = ($urandom_range(0, 15) == 0);
            drive("rand", s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_pair_scheduler.md
# issue_pair_scheduler

Sequences dual issue from the decode stage of the two-lane superscalar pipeline. Each cycle it decides whether the decoded instruction pair enters ID/EX together or must be split because of an intra-pair conflict. On a split it issues slot 1 first, holds IF/ID, and issues the held slot 2 on lane 1 the next cycle. It sits between the IF/ID register and ID/EX, downstream of the hazard-detection stall/flush outputs.

## Interface
- CNT_W, 16, width of the saturating split-event counter

- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- validD1, validD2  input  1  decode slot holds a real instruction
- rsD1, rtD1, rsD2, rtD2  input  5  source registers
- writeRegD1, writeRegD2  input  5  destination registers
- regWriteD1, regWriteD2  input  1  slot writes its destination
- memAccD1, memAccD2  input  1  slot is a load or store (single data-memory port)
- stallD  input  1  OR of the hazard unit's decode stalls
- flushD  input  1  OR of the hazard unit's decode flushes
- issue1, issue2  output  1  lane 1 / lane 2 ID/EX valid
- laneSel  output  1  0: lane 1 takes slot 1; 1: lane 1 takes slot 2 (held)
- holdIFID  output  1  freeze PC and IF/ID this cycle
- conflict  output  2  0 none, 1 RAW, 2 WAW, 3 MEM (current pair, PAIR state only)
- splitCount  output  CNT_W  saturating count of splits

## Operation
- Two states: PAIR (reset) and SPLIT. The state register and splitCount are the only flops. Issue outputs are combinational from state and inputs.
- Conflict detection, evaluated only when validD1 && validD2, in priority order RAW > WAW > MEM:
  - RAW: regWriteD1 && writeRegD1≠0 && (writeRegD1==rsD2 || writeRegD1==rtD2)
  - WAW: regWriteD1 && regWriteD2 && writeRegD1==writeRegD2 && writeRegD1≠0
  - MEM: memAccD1 && memAccD2
- PAIR:
  - No conflict: issue1=validD1, issue2=validD2, laneSel=0, holdIFID=0; stay in PAIR.
  - Conflict: issue1=1, issue2=0, laneSel=0, holdIFID=1; go to SPLIT; increment splitCount (saturate at all-ones).
  - validD1=0 with validD2=1: not a conflict; slot 2 issues on lane 2.
- SPLIT: issue1=validD2, issue2=0, laneSel=1, holdIFID=0; go to PAIR.
- stallD=1, any state: issue1=issue2=0, holdIFID=1. State and counter hold, conflict still reported.
- flushD=1, any state: issue1=issue2=0, holdIFID=0, next state PAIR, counter holds. flushD takes precedence over stallD.
- While rst is low: all outputs 0, state PAIR, splitCount 0.

## Timing
- Decision latency 0: issue/hold/laneSel are valid in the same cycle as the decode inputs.
- State update occurs at the rising edge. A split costs exactly one extra cycle per conflicting pair.
- stallD in SPLIT delays issue of the held slot 2 until the first cycle with stallD=0.
- flushD in SPLIT discards the held slot 2. The next cycle is PAIR with new IF/ID contents.
- Reset asserted mid-SPLIT returns to PAIR immediately (asynchronous). The held instruction is lost; this is acceptable because reset refetches.
- Counter increments only on a PAIR→SPLIT transition, not while stalled.

## Structure
- The shared package superscalar_pkg holds:
  - state encoding (ST_PAIR=1'b0, ST_SPLIT=1'b1)
  - conflict codes (CF_NONE, CF_RAW, CF_WAW, CF_MEM)
  - REG_W=5
- One sub-module, pair_conflict_check: purely combinational, producing the 2-bit conflict code from slot fields. It is reused by the planned issue-width monitor.
- The top level holds the FSM, output decode and counter.

## Test plan
- Independent pair: slot1 add $3, slot2 sub $5 (reads $6,$7) → issue1=issue2=1, laneSel=0, state stays PAIR, splitCount=0.
- RAW pair: slot1 writes $8, slot2 reads rt=$8 → cycle 0: conflict=1, issue1=1, issue2=0, holdIFID=1; cycle 1: issue1=1, laneSel=1, holdIFID=0; splitCount=1.
- $0 and MEM: slot1 writes $0 and slot2 reads $0 → no split. Two loads → conflict=3, split.
- Stall in SPLIT: RAW split, then stallD=1 for 2 cycles → issue1=0, holdIFID=1 for both cycles; held slot 2 issues with laneSel=1 on the 3rd cycle.
- Flush in SPLIT plus reset: flushD=1 in SPLIT → no issue, next state PAIR. Assert rst low mid-SPLIT → all outputs 0, splitCount=0. Drive 2^CNT_W+3 splits → splitCount saturates at all-ones.
